mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Merges the CPU core's separate instruction-fetch and data ports (cpu_ram_if semantics: iren/iaddr/iload/iwait, dren/dwen/daddr/dstore/dload/dwait) onto one single-ported, variable-latency RAM port. It sits directly downstream of the datapath's fetch (stage 1) and memory (stage 4) accesses. Data accesses take priority. Wait signals stay asserted until the granted access completes, which lets the hazard unit stall the pipeline on ~iwait / ~dwait.

## Interface
Parameters:
- RAM_RESET_ADDR, 32'h0: value driven on ram_addr while idle and after reset.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- iren  in  1  instruction read request
- iaddr  in  32  instruction byte address, word-aligned
- iload  out  32  instruction data, valid when iwait=0
- iwait  out  1  0 = instruction access completes this cycle
- dren  in  1  data read request
- dwen  in  4  data byte write enables; nonzero = write request
- daddr  in  32  data byte address
- dstore  in  32  pre-aligned store data
- dload  out  32  data read word, valid when dwait=0
- dwait  out  1  0 = data access completes this cycle
- ram_ren  out  1  RAM read strobe
- ram_wen  out  4  RAM byte write strobes
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM completes the current access this cycle; may be high in the first strobe cycle

## Operation
- FSM states: IDLE, IBUSY, DBUSY (arb_state_t).
- Grant rule. When no access is outstanding, a data request (dren | |dwen) wins over iren. Request fields are latched into req_addr, req_wen, req_ren and req_wdata on the grant edge.
- In IBUSY/DBUSY, RAM strobes are driven only from the latched fields, never from live inputs.
- Completion is the cycle in BUSY with ram_ready=1.
  - IBUSY: iload = ram_rdata; iwait = 0 only if iren=1 and iaddr still equals req_addr. Otherwise the result is discarded.
  - DBUSY: dload = ram_rdata; dwait = 0 only if the live dren, dwen and daddr equal the latched values. A write that was issued has still been performed.
- Chaining. At completion, the next grant is evaluated over the other port only. If it is requesting, go straight to its BUSY state and latch its fields. Otherwise go to IDLE.
- From IDLE, a grant moves to the BUSY state on the next edge.
- Outside a completion or buffer hit: iwait=1, dwait=1, iload and dload hold their last returned values.
- Simultaneous requests: data is served first; instruction is chained immediately after.
- dren together with nonzero dwen is treated as a write (ram_ren=0).

## Timing
- Reset values:
  - state=IDLE, iwait=1, dwait=1, iload=32'h00000013, dload=0.
  - ram_ren=0, ram_wen=0, ram_addr=RAM_RESET_ADDR, ram_wdata=0.
- Latency with a zero-wait RAM (ready in the first strobe cycle):
  - Isolated access: request in cycle N, strobe plus completion in cycle N+1.
  - Chained access: the second access completes in N+2.
- RAM stalls extend BUSY one cycle per ready=0 cycle. The strobes stay stable throughout.
- Reset mid-access: state goes to IDLE immediately and strobes drop asynchronously. The outstanding RAM access is abandoned; the RAM must tolerate strobe removal.

## Configuration
- MEM_ARBITER_IBUF_EN: compiles in a one-entry instruction buffer (valid, tag = iaddr[31:2], data).
  - Fill: on every accepted instruction completion.
  - Hit: iren=1, valid, and tag match. The hit is served combinationally in any state, including during DBUSY: iwait=0, iload=buffer data, and no RAM grant is made for the instruction port.
  - Invalidate: on a data write grant whose daddr[31:2] equals the tag, and on reset.
  - A write and a hit to the same word in the grant cycle return the miss path.
- Without the macro, every fetch goes to RAM. A stalled fetch re-reads the RAM on each access.

## Structure
- In common_types_pkg:
  - arb_state_t enum {IDLE, IBUSY, DBUSY}
  - NOP_INST constant 32'h00000013
  - word_t, already defined there
- Sub-module mem_arbiter_ibuf, instantiated only under MEM_ARBITER_IBUF_EN. It holds the buffer registers, hit logic and invalidate compare.
- Target size: about 200 lines for mem_arbiter and 60 for the sub-module.

## Test plan
- Isolated fetch, zero-wait RAM: iren=1, iaddr=0x100, ram_rdata=0xDEADBEEF. Expect ram_ren=1 and ram_addr=0x100 one cycle later, with iwait=0 and iload=0xDEADBEEF in that same cycle.
- Simultaneous requests: iren with iaddr=0x10, and dren with daddr=0x200. Expect the data access to complete first (dwait=0), then the instruction access chained to complete in the next cycle.
- RAM stall: ram_ready held low for 3 cycles during a word store of dwen=4'hF, daddr=0x40, dstore=0x12345678. Expect the strobes stable for 4 cycles, dwait=1 until the ready cycle, and exactly one write.
- Request change mid-access: iaddr changes from 0x20 to 0x80 before ram_ready. Expect iwait to stay 1 at the completion of 0x20, then a new access to 0x80.
- Asynchronous reset mid-DBUSY: expect all RAM strobes 0 immediately, state IDLE, iwait=dwait=1, iload=0x00000013.
- With MEM_ARBITER_IBUF_EN: a repeat fetch of 0x100 hits with iwait=0 and no ram_ren. A store to 0x100 invalidates the entry, so the next fetch of 0x100 goes to RAM.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types and constants for the memory subsystem.
package common_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WEN_W  = 4;
  localparam int unsigned TAG_W  = 30;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WEN_W-1:0]  wen_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  // addi x0, x0, 0: what the fetch port shows before any fetch returns
  localparam word_t NOP_INST = 32'h00000013;

  // Word index of a byte address
  function automatic tag_t word_tag(input word_t addr);
    return addr[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_ibuf.sv
// One-entry instruction buffer: holds the last accepted fetch word and
// serves repeat fetches of it without a RAM access.
module mem_arbiter_ibuf
  import common_types_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              iren,
  input  logic [TAG_W-1:0]  itag,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [WORD_W-1:0] fill_data,
  input  logic              inval,
  input  logic [TAG_W-1:0]  inval_tag,
  output logic              hit_c,
  output logic [WORD_W-1:0] data
);

  logic  valid;
  tag_t  tag;
  word_t buf_data;
  logic  inval_hit_c;
  logic  fill_keep_c;

  // A granted write to the buffered word kills the entry and any hit on it
  assign inval_hit_c = inval && (inval_tag == tag);
  // A fill racing a write to the same word would capture pre-write data
  assign fill_keep_c = !(inval && (inval_tag == fill_tag));

  // Hit is served combinationally; a same-word write in this cycle forces a miss
  assign hit_c = iren && valid && (itag == tag) && !inval_hit_c;
  assign data  = buf_data;

  // Buffer entry: fill on accepted fetch completion, clear on matching write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid    <= 1'b0;
      tag      <= '0;
      buf_data <= '0;
    end else if (fill) begin
      valid    <= fill_keep_c;
      tag      <= fill_tag;
      buf_data <= fill_data;
    end else if (inval_hit_c) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the CPU instruction and data ports onto one variable-latency RAM
// port; data has priority, a pending instruction fetch chains after it.
// Build option: MEM_ARBITER_IBUF_EN adds a one-entry instruction buffer.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter logic [31:0] RAM_RESET_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              iren,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dren,
  input  logic [WEN_W-1:0]  dwen,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ram_ren,
  output logic [WEN_W-1:0]  ram_wen,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  arb_state_t state;
  arb_state_t state_nxt;

  word_t req_addr;
  word_t req_wdata;
  wen_t  req_wen;
  logic  req_ren;
  logic  req_dren;

  word_t iload_q;
  word_t dload_q;

  logic  busy_c;
  logic  dreq_c;
  logic  ireq_c;
  logic  ihit_c;
  word_t ibuf_data_c;
  logic  icomp_c;
  logic  dcomp_c;
  logic  d_grant_c;
  logic  i_grant_c;
  logic  iaccept_c;
  logic  daccept_c;

  assign busy_c  = (state != IDLE);
  assign dreq_c  = dren || (dwen != '0);
  assign ireq_c  = iren && !ihit_c;
  assign icomp_c = (state == IBUSY) && ram_ready;
  assign dcomp_c = (state == DBUSY) && ram_ready;

  // Grants: from IDLE data wins; at a completion only the other port is considered
  assign d_grant_c = dreq_c && ((state == IDLE) || icomp_c);
  assign i_grant_c = ireq_c && !d_grant_c && ((state == IDLE) || dcomp_c);

  // A completion is only handed back if the port still asks for the same access
  assign iaccept_c = icomp_c && iren && (iaddr == req_addr);
  assign daccept_c = dcomp_c && (dren == req_dren) && (dwen == req_wen) &&
                     (daddr == req_addr);

`ifdef MEM_ARBITER_IBUF_EN
  mem_arbiter_ibuf u_ibuf (
    .clk       (clk),
    .nrst      (nrst),
    .iren      (iren),
    .itag      (word_tag(iaddr)),
    .fill      (iaccept_c),
    .fill_tag  (word_tag(req_addr)),
    .fill_data (ram_rdata),
    .inval     (d_grant_c && (dwen != '0)),
    .inval_tag (word_tag(daddr)),
    .hit_c     (ihit_c),
    .data      (ibuf_data_c)
  );
`else
  assign ihit_c      = 1'b0;
  assign ibuf_data_c = NOP_INST;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, RAM strobes from latched fields, and port handshakes
  always_comb begin
    state_nxt = state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = iload_q;
    dload     = dload_q;
    ram_ren   = 1'b0;
    ram_wen   = '0;
    ram_addr  = RAM_RESET_ADDR;
    ram_wdata = '0;

    if (d_grant_c) begin
      state_nxt = DBUSY;
    end else if (i_grant_c) begin
      state_nxt = IBUSY;
    end else if (icomp_c || dcomp_c) begin
      state_nxt = IDLE;
    end

    if (busy_c) begin
      ram_ren   = req_ren;
      ram_wen   = req_wen;
      ram_addr  = req_addr;
      ram_wdata = req_wdata;
    end

    if (iaccept_c) begin
      iwait = 1'b0;
      iload = ram_rdata;
    end else if (ihit_c) begin
      iwait = 1'b0;
      iload = ibuf_data_c;
    end

    if (daccept_c) begin
      dwait = 1'b0;
      dload = ram_rdata;
    end
  end

  // Request fields captured on the grant edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_addr  <= RAM_RESET_ADDR;
      req_wen   <= '0;
      req_ren   <= 1'b0;
      req_dren  <= 1'b0;
      req_wdata <= '0;
    end else if (d_grant_c) begin
      req_addr  <= daddr;
      req_wen   <= dwen;
      req_ren   <= dren && (dwen == '0);
      req_dren  <= dren;
      req_wdata <= dstore;
    end else if (i_grant_c) begin
      req_addr  <= iaddr;
      req_wen   <= '0;
      req_ren   <= 1'b1;
      req_dren  <= 1'b0;
      req_wdata <= '0;
    end
  end

  // Last returned words, held between completions
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      iload_q <= NOP_INST;
      dload_q <= '0;
    end else begin
      iload_q <= iload;
      dload_q <= dload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hand-driven RAM port.
module tb_mem_arbiter;
  import common_types_pkg::*;

  logic        clk;
  logic        nrst;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int wr_start = 0;

  mem_arbiter #(.RAM_RESET_ADDR(32'h0)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .iren      (iren),
    .iaddr     (iaddr),
    .iload     (iload),
    .iwait     (iwait),
    .dren      (dren),
    .dwen      (dwen),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dwait     (dwait),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ready (ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed RAM writes
  always @(posedge clk) begin
    if (nrst && ram_ready && (ram_wen != 4'h0)) wr_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = '0;
    daddr = '0; dstore = '0; ram_rdata = '0; ram_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    #1;

    // Reset values
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_iload", iload, 32'h00000013);
    check("rst_dload", dload, 32'h0);
    check("rst_ram_ren", 32'(ram_ren), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);

    // Isolated fetch, zero-wait RAM
    iren = 1'b1; iaddr = 32'h100; ram_rdata = 32'hDEADBEEF; #1;
    check("t1_req_ren", 32'(ram_ren), 32'd0);
    check("t1_req_iwait", 32'(iwait), 32'd1);
    next_cycle(); #1;
    check("t1_ram_ren", 32'(ram_ren), 32'd1);
    check("t1_ram_addr", ram_addr, 32'h100);
    check("t1_iwait", 32'(iwait), 32'd0);
    check("t1_iload", iload, 32'hDEADBEEF);
    next_cycle(); iren = 1'b0; #1;
    check("t1_after_iwait", 32'(iwait), 32'd1);
    check("t1_after_iload", iload, 32'hDEADBEEF);
    check("t1_after_ren", 32'(ram_ren), 32'd0);

    // Simultaneous requests: data first, fetch chained
    iren = 1'b1; iaddr = 32'h10; dren = 1'b1; daddr = 32'h200;
    ram_rdata = 32'hA5A5A5A5; #1;
    next_cycle(); #1;
    check("t2_dwait", 32'(dwait), 32'd0);
    check("t2_dload", dload, 32'hA5A5A5A5);
    check("t2_d_addr", ram_addr, 32'h200);
    check("t2_d_ren", 32'(ram_ren), 32'd1);
    check("t2_d_iwait", 32'(iwait), 32'd1);
    next_cycle(); dren = 1'b0; ram_rdata = 32'h11112222; #1;
    check("t2_iwait", 32'(iwait), 32'd0);
    check("t2_iload", iload, 32'h11112222);
    check("t2_i_addr", ram_addr, 32'h10);
    check("t2_i_dwait", 32'(dwait), 32'd1);
    check("t2_dload_hold", dload, 32'hA5A5A5A5);
    next_cycle(); iren = 1'b0; #1;
    check("t2_idle_ren", 32'(ram_ren), 32'd0);
    check("t2_idle_iwait", 32'(iwait), 32'd1);

    // Stalled word store: three not-ready cycles then ready
    wr_start = wr_count;
    dwen = 4'hF; daddr = 32'h40; dstore = 32'h12345678; ram_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ram_ready = (i == 3); #1;
      check($sformatf("t3_wen_%0d", i), 32'(ram_wen), 32'hF);
      check($sformatf("t3_addr_%0d", i), ram_addr, 32'h40);
      check($sformatf("t3_wdata_%0d", i), ram_wdata, 32'h12345678);
      check($sformatf("t3_ren_%0d", i), 32'(ram_ren), 32'd0);
      check($sformatf("t3_dwait_%0d", i), 32'(dwait), (i == 3) ? 32'd0 : 32'd1);
    end
    next_cycle(); dwen = 4'h0; #1;
    check("t3_writes", 32'(wr_count - wr_start), 32'd1);
    check("t3_idle_wen", 32'(ram_wen), 32'd0);

    // Fetch address changes before the RAM answers
    iren = 1'b1; iaddr = 32'h20; ram_ready = 1'b0; ram_rdata = 32'hCAFE0020; #1;
    next_cycle(); iaddr = 32'h80; #1;
    check("t4_latched_addr", ram_addr, 32'h20);
    check("t4_busy_ren", 32'(ram_ren), 32'd1);
    check("t4_busy_iwait", 32'(iwait), 32'd1);
    next_cycle(); ram_ready = 1'b1; #1;
    check("t4_discard_iwait", 32'(iwait), 32'd1);
    check("t4_discard_addr", ram_addr, 32'h20);
    next_cycle(); ram_rdata = 32'hBEEF0080; #1;
    check("t4_idle_ren", 32'(ram_ren), 32'd0);
    check("t4_idle_iwait", 32'(iwait), 32'd1);
    next_cycle(); #1;
    check("t4_new_addr", ram_addr, 32'h80);
    check("t4_new_iwait", 32'(iwait), 32'd0);
    check("t4_new_iload", iload, 32'hBEEF0080);
    next_cycle(); iren = 1'b0; #1;

    // Asynchronous reset in the middle of a data access
    dren = 1'b1; daddr = 32'h300; ram_ready = 1'b0; #1;
    next_cycle(); #1;
    check("t5_busy_ren", 32'(ram_ren), 32'd1);
    check("t5_busy_addr", ram_addr, 32'h300);
    nrst = 1'b0; #1;
    check("t5_ren", 32'(ram_ren), 32'd0);
    check("t5_wen", 32'(ram_wen), 32'd0);
    check("t5_addr", ram_addr, 32'h0);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    check("t5_iwait", 32'(iwait), 32'd1);
    check("t5_dwait", 32'(dwait), 32'd1);
    check("t5_iload", iload, 32'h00000013);
    dren = 1'b0; ram_ready = 1'b1;
    @(negedge clk); nrst = 1'b1; #1;

`ifdef MEM_ARBITER_IBUF_EN
    // Buffer fill, hit, and invalidation by a store to the same word
    iren = 1'b1; iaddr = 32'h100; ram_rdata = 32'h0BADF00D; #1;
    next_cycle(); #1;
    check("t6_fill_iwait", 32'(iwait), 32'd0);
    next_cycle(); ram_rdata = 32'hFFFFFFFF; #1;
    check("t6_hit_iwait", 32'(iwait), 32'd0);
    check("t6_hit_iload", iload, 32'h0BADF00D);
    check("t6_hit_ren", 32'(ram_ren), 32'd0);
    iren = 1'b0;
    next_cycle(); dwen = 4'hF; daddr = 32'h100; dstore = 32'h0; #1;
    next_cycle(); #1;
    check("t6_st_dwait", 32'(dwait), 32'd0);
    check("t6_st_wen", 32'(ram_wen), 32'hF);
    next_cycle(); dwen = 4'h0; iren = 1'b1; iaddr = 32'h100; ram_rdata = 32'h55AA55AA; #1;
    check("t6_miss_iwait", 32'(iwait), 32'd1);
    check("t6_miss_idle_ren", 32'(ram_ren), 32'd0);
    next_cycle(); #1;
    check("t6_refetch_ren", 32'(ram_ren), 32'd1);
    check("t6_refetch_addr", ram_addr, 32'h100);
    check("t6_refetch_iwait", 32'(iwait), 32'd0);
    check("t6_refetch_iload", iload, 32'h55AA55AA);
    next_cycle(); iren = 1'b0; #1;
`else
    // Without the buffer a repeat fetch goes back to RAM
    iren = 1'b1; iaddr = 32'h100; ram_rdata = 32'h0BADF00D; #1;
    next_cycle(); #1;
    check("t6_first_iwait", 32'(iwait), 32'd0);
    next_cycle(); ram_rdata = 32'h55AA55AA; #1;
    check("t6_repeat_idle_iwait", 32'(iwait), 32'd1);
    check("t6_repeat_idle_ren", 32'(ram_ren), 32'd0);
    next_cycle(); #1;
    check("t6_repeat_ren", 32'(ram_ren), 32'd1);
    check("t6_repeat_addr", ram_addr, 32'h100);
    check("t6_repeat_iload", iload, 32'h55AA55AA);
    next_cycle(); iren = 1'b0; #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
